// File: rtl/io_input_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_input_scan_pkg
//  Description : Shared definitions for the switch/button input scanner:
//                read-port address map, default debounce tick period and
//                the history-agreement helper used by every debounced bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_input_scan_pkg;

    // Read-port register map
    localparam logic [1:0] ADDR_SW    = 2'd0;
    localparam logic [1:0] ADDR_BTN   = 2'd1;
    localparam logic [1:0] ADDR_PRESS = 2'd2;
    localparam logic [1:0] ADDR_RSVD  = 2'd3;

    // Default number of clk cycles between debounce samples
    localparam int TICK_CYCLES_DEFAULT = 2000;

    // True when the three most recent samples agree with each other and
    // disagree with the currently published stable level.
    function automatic logic hist_agree(input logic [2:0] hist, input logic cur);
        return ((hist == 3'b111) && !cur) || ((hist == 3'b000) && cur);
    endfunction

endpackage : io_input_scan_pkg
`default_nettype wire

// File: rtl/io_input_scan_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : io_debounce_bit
//  Description : One raw input line: 2-flop synchronizer, 3-deep sample
//                history loaded on each tick, and a stable register that
//                only follows the history once all three samples agree.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_debounce_bit
    import io_input_scan_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic stable
);

    logic       r_sync1;
    logic       r_sync2;
    logic [2:0] r_hist;
    logic       r_stable;
    logic       w_flip;

    // Two-flop synchronizer; r_sync2 is the clean, clk-domain level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Shift the synced level into the history once per tick (newest in bit 0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= 3'b000;
        end else if (tick) begin
            r_hist <= {r_hist[1:0], r_sync2};
        end
    end

    // The history only moves on ticks, so evaluating it every cycle makes the
    // stable level change exactly one cycle after the tick that completed a
    // unanimous history; any disagreement among samples holds the level.
    assign w_flip = hist_agree(r_hist, r_stable);

    // Stable level register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= 1'b0;
        end else if (w_flip) begin
            r_stable <= ~r_stable;
        end
    end

    assign stable = r_stable;

endmodule : io_debounce_bit
`default_nettype wire

// File: rtl/io_input_scan.sv
`default_nettype none
// ============================================================================
//  Module      : io_input_scan
//  Description : Input-side companion to the 7-segment/LED driver. Debounces
//                slide switches and push buttons, generates press pulses and
//                sticky press flags, and exposes them through a small
//                registered read port (reading the flags clears them).
//  Revision    : 1.0 - initial release
// ============================================================================
module io_input_scan
    import io_input_scan_pkg::*;
#(
    parameter int SW_W        = 16,
    parameter int BTN_W       = 4,
    parameter int TICK_CYCLES = TICK_CYCLES_DEFAULT,
    parameter int CNT_W       = 20
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [SW_W-1:0]   sw_raw,
    input  logic [BTN_W-1:0]  btn_raw,
    output logic [SW_W-1:0]   sw_stable,
    output logic [BTN_W-1:0]  btn_stable,
    output logic [BTN_W-1:0]  btn_press,
    output logic              event_pending,
    input  logic              rd_req,
    input  logic [1:0]        rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_ack
);

    localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;

    logic [SW_W-1:0]  w_sw_stable;
    logic [BTN_W-1:0] w_btn_stable;
    logic [BTN_W-1:0] r_btn_seen;
    logic [BTN_W-1:0] w_btn_press;

    logic [BTN_W-1:0] r_press_flag;
    logic [BTN_W-1:0] w_press_flag_next;
    logic             r_event_pending;
    logic             w_flag_clear;

    logic [31:0]      w_rd_mux;
    logic [31:0]      r_rd_data;
    logic             r_rd_ack;

    // ------------------------------------------------------------------
    // Debounce sample tick: one pulse every TICK_CYCLES clocks
    // ------------------------------------------------------------------
    assign w_tick = (r_tick_cnt == c_tick_last);

    // Free-running tick counter, wraps after the tick cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-line debouncers
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SW_W; gi++) begin : g_sw
            io_debounce_bit u_db (
                .clk    (clk),
                .reset  (reset),
                .raw    (sw_raw[gi]),
                .tick   (w_tick),
                .stable (w_sw_stable[gi])
            );
        end
        for (gi = 0; gi < BTN_W; gi++) begin : g_btn
            io_debounce_bit u_db (
                .clk    (clk),
                .reset  (reset),
                .raw    (btn_raw[gi]),
                .tick   (w_tick),
                .stable (w_btn_stable[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Press detection: the pulse coincides with the first cycle of a
    // debounced high level, so it is taken against a one-cycle-old copy.
    // ------------------------------------------------------------------
    // Remember last cycle's debounced button levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_seen <= '0;
        end else begin
            r_btn_seen <= w_btn_stable;
        end
    end

    assign w_btn_press = w_btn_stable & ~r_btn_seen;

    // ------------------------------------------------------------------
    // Sticky press flags; a set in the same cycle as a clear wins.
    // ------------------------------------------------------------------
    assign w_flag_clear = rd_req && (rd_addr == ADDR_PRESS);

    // Next flag value: optional clear, then OR in this cycle's presses.
    always_comb begin
        w_press_flag_next = r_press_flag;
        if (w_flag_clear) begin
            w_press_flag_next = '0;
        end
        w_press_flag_next = w_press_flag_next | w_btn_press;
    end

    // Flag and summary registers updated together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_press_flag    <= '0;
            r_event_pending <= 1'b0;
        end else begin
            r_press_flag    <= w_press_flag_next;
            r_event_pending <= |w_press_flag_next;
        end
    end

    // ------------------------------------------------------------------
    // Read port: captured at the accepting edge, presented one cycle later.
    // Flags are returned as they were before this read's clear.
    // ------------------------------------------------------------------
    // Register select, zero-extended to the 32-bit data bus.
    always_comb begin
        w_rd_mux = 32'h0000_0000;
        case (rd_addr)
            ADDR_SW:    w_rd_mux = 32'(w_sw_stable);
            ADDR_BTN:   w_rd_mux = 32'(w_btn_stable);
            ADDR_PRESS: w_rd_mux = 32'(r_press_flag);
            ADDR_RSVD:  w_rd_mux = 32'h0000_0000;
            default:    w_rd_mux = 32'h0000_0000;
        endcase
    end

    // Read data holds between requests; ack mirrors the previous request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= 32'h0000_0000;
            r_rd_ack  <= 1'b0;
        end else begin
            r_rd_ack <= rd_req;
            if (rd_req) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sw_stable     = w_sw_stable;
    assign btn_stable    = w_btn_stable;
    assign btn_press     = w_btn_press;
    assign event_pending = r_event_pending;
    assign rd_data       = r_rd_data;
    assign rd_ack        = r_rd_ack;

endmodule : io_input_scan
`default_nettype wire

// File: tb/tb_io_input_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_input_scan
//  Description : Self-checking bench for io_input_scan with a sample-list
//                reference model, per-cycle comparison and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_io_input_scan;

    localparam int SW_W  = 16;
    localparam int BTN_W = 4;
    localparam int TICK  = 4;
    localparam int N     = SW_W + BTN_W;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic [SW_W-1:0]   sw_raw;
    logic [BTN_W-1:0]  btn_raw;
    logic [SW_W-1:0]   sw_stable;
    logic [BTN_W-1:0]  btn_stable;
    logic [BTN_W-1:0]  btn_press;
    logic              event_pending;
    logic              rd_req;
    logic [1:0]        rd_addr;
    logic [31:0]       rd_data;
    logic              rd_ack;

    int total = 0;
    int bad   = 0;

    io_input_scan #(
        .SW_W        (SW_W),
        .BTN_W       (BTN_W),
        .TICK_CYCLES (TICK),
        .CNT_W       (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sw_raw        (sw_raw),
        .btn_raw       (btn_raw),
        .sw_stable     (sw_stable),
        .btn_stable    (btn_stable),
        .btn_press     (btn_press),
        .event_pending (event_pending),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_ack        (rd_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: raw levels are seen two edges late, a sample is
    // appended at every tick edge (edge index mod TICK == TICK-1 counted
    // from reset release), and the edge after a tick the stable word takes
    // every bit whose last three samples agree.
    // ------------------------------------------------------------------
    logic [N-1:0]     m_d1, m_d2, m_s0, m_s1, m_s2, m_stable;
    logic             m_eval, m_ack, m_ev;
    logic [BTN_W-1:0] m_press, m_flags;
    logic [31:0]      m_data;
    int               m_edge;

    logic [N-1:0]     mn_d1, mn_d2, mn_s0, mn_s1, mn_s2, mn_stable, all1, all0;
    logic             mn_eval, mn_ack, mn_ev, tick_now;
    logic [BTN_W-1:0] mn_press, mn_flags;
    logic [31:0]      mn_data;

    always_comb begin
        all1      = m_s0 & m_s1 & m_s2;
        all0      = ~(m_s0 | m_s1 | m_s2);
        mn_stable = m_stable;
        if (m_eval) mn_stable = (m_stable | all1) & ~all0;
        mn_press  = mn_stable[N-1:SW_W] & ~m_stable[N-1:SW_W];
        tick_now  = (m_edge % TICK) == (TICK - 1);
        mn_eval   = tick_now;
        mn_s0     = tick_now ? m_d2 : m_s0;
        mn_s1     = tick_now ? m_s0 : m_s1;
        mn_s2     = tick_now ? m_s1 : m_s2;
        mn_d1     = {btn_raw, sw_raw};
        mn_d2     = m_d1;
        mn_ack    = rd_req;
        mn_data   = m_data;
        if (rd_req) begin
            case (rd_addr)
                2'd0:    mn_data = {16'h0000, m_stable[SW_W-1:0]};
                2'd1:    mn_data = {28'h0, m_stable[N-1:SW_W]};
                2'd2:    mn_data = {28'h0, m_flags};
                default: mn_data = 32'h0;
            endcase
        end
        mn_flags = ((rd_req && rd_addr == 2'd2) ? 4'h0 : m_flags) | m_press;
        mn_ev    = |mn_flags;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_d1 <= '0; m_d2 <= '0; m_s0 <= '0; m_s1 <= '0; m_s2 <= '0;
            m_stable <= '0; m_eval <= 1'b0; m_press <= '0; m_flags <= '0;
            m_ev <= 1'b0; m_ack <= 1'b0; m_data <= '0; m_edge <= 0;
        end else begin
            m_d1 <= mn_d1; m_d2 <= mn_d2; m_s0 <= mn_s0; m_s1 <= mn_s1;
            m_s2 <= mn_s2; m_stable <= mn_stable; m_eval <= mn_eval;
            m_press <= mn_press; m_flags <= mn_flags; m_ev <= mn_ev;
            m_ack <= mn_ack; m_data <= mn_data; m_edge <= m_edge + 1;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("model sw_stable", 32'(sw_stable), {16'h0, m_stable[SW_W-1:0]});
            chk("model btn_stable", 32'(btn_stable), {28'h0, m_stable[N-1:SW_W]});
            chk("model btn_press", 32'(btn_press), {28'h0, m_press});
            chk("model event_pending", 32'(event_pending), {31'h0, m_ev});
            chk("model rd_ack", 32'(rd_ack), {31'h0, m_ack});
            if (m_ack) chk("model rd_data", rd_data, m_data);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic do_read(input logic [1:0] addr, input logic [31:0] exp,
                           input string name, output logic ev_at_ack);
        rd_req  = 1'b1;
        rd_addr = addr;
        @(negedge clk);
        chk({name, " ack"}, 32'(rd_ack), 32'h1);
        chk({name, " data"}, rd_data, exp);
        ev_at_ack = event_pending;
        rd_req = 1'b0;
        @(negedge clk);
        chk({name, " ack drop"}, 32'(rd_ack), 32'h0);
    endtask

    task automatic wait_sw(input logic [SW_W-1:0] exp, output int n);
        n = 0;
        while (sw_stable !== exp && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_press(input int bit_i, input string name);
        int n;
        n = 0;
        while (btn_press[bit_i] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " seen"}, 32'(btn_press[bit_i]), 32'h1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " sw_stable"}, 32'(sw_stable), 32'h0);
        chk({name, " btn_stable"}, 32'(btn_stable), 32'h0);
        chk({name, " btn_press"}, 32'(btn_press), 32'h0);
        chk({name, " event_pending"}, 32'(event_pending), 32'h0);
        chk({name, " rd_ack"}, 32'(rd_ack), 32'h0);
        chk({name, " rd_data"}, rd_data, 32'h0);
    endtask

    initial begin
        int n, pc;
        logic ev;
        logic [BTN_W-1:0] pv;
        sw_raw = '0; btn_raw = '0; rd_req = 1'b0; rd_addr = 2'd0;
        #1 reset = 1'b1;
        #1 chk_all_zero("reset");

        // Steady switch pattern: raw at edge 0, stable visible 13 negedges later
        @(negedge clk);
        sw_raw = 16'hA5C3;
        reset  = 1'b0;
        wait_sw(16'hA5C3, n);
        chk("sw settle value", 32'(sw_stable), 32'h0000_A5C3);
        chk("sw settle latency", 32'(n), 32'd13);
        do_read(2'd0, 32'h0000_A5C3, "read sw", ev);

        // Glitch shorter than one tick period
        btn_raw = 4'b0100;
        repeat (3) @(negedge clk);
        btn_raw = 4'b0000;
        repeat (20) @(negedge clk);
        chk("glitch btn_stable", 32'(btn_stable), 32'h0);
        chk("glitch event_pending", 32'(event_pending), 32'h0);

        // Long press on button 1, then release
        btn_raw = 4'b0010;
        pc = 0; pv = '0;
        for (int i = 0; i < 45; i++) begin
            if (i == 20) btn_raw = 4'b0000;
            @(negedge clk);
            if (btn_press != 4'b0000) begin
                pc++;
                pv = btn_press;
            end
        end
        chk("press pulse count", 32'(pc), 32'd1);
        chk("press pulse value", 32'(pv), 32'h2);
        chk("release btn_stable", 32'(btn_stable), 32'h0);
        chk("pending after release", 32'(event_pending), 32'h1);

        // Flag read clears
        do_read(2'd2, 32'h2, "read flags", ev);
        chk("pending cleared", 32'(ev), 32'h0);
        do_read(2'd2, 32'h0, "reread flags", ev);

        // Read coinciding with a new press: old flags returned, new flag kept
        btn_raw = 4'b1000;
        wait_press(3, "press3");
        repeat (2) @(negedge clk);
        btn_raw = 4'b1001;
        wait_press(0, "press0");
        rd_req = 1'b1; rd_addr = 2'd2;
        @(negedge clk);
        chk("collide ack", 32'(rd_ack), 32'h1);
        chk("collide data", rd_data, 32'h8);
        rd_req = 1'b0;
        @(negedge clk);
        chk("collide pending", 32'(event_pending), 32'h1);
        do_read(2'd2, 32'h1, "collide reread", ev);
        btn_raw = 4'b0000;
        repeat (20) @(negedge clk);

        // Reset mid-debounce
        sw_raw  = 16'hFFFF;
        btn_raw = 4'b0101;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_all_zero("mid reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_sw(16'hFFFF, n);
        chk("post reset sw", 32'(sw_stable), 32'h0000_FFFF);
        chk("post reset latency", 32'(n), 32'd13);
        chk("post reset btn", 32'(btn_stable), 32'h5);

        // Back-to-back reads
        rd_req = 1'b1; rd_addr = 2'd0;
        @(negedge clk);
        chk("b2b ack0", 32'(rd_ack), 32'h1);
        chk("b2b data0", rd_data, 32'h0000_FFFF);
        rd_addr = 2'd1;
        @(negedge clk);
        chk("b2b ack1", 32'(rd_ack), 32'h1);
        chk("b2b data1", rd_data, 32'h5);
        rd_addr = 2'd3;
        @(negedge clk);
        chk("b2b ack3", 32'(rd_ack), 32'h1);
        chk("b2b data3", rd_data, 32'h0);
        rd_req = 1'b0;
        @(negedge clk);
        chk("b2b ack end", 32'(rd_ack), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_io_input_scan
`default_nettype wire

// File: doc/io_input_scan.md
Name: io_input_scan

Overview:
- Input-side companion to the board's 7-segment/LED output driver. It turns the raw slide switches and push buttons into clean values the CPU can read.
- Each raw line passes through a 2-flop synchronizer and a tick-sampled 3-sample debouncer.
- It generates one-cycle press pulses and sticky press flags.
- A small registered read port lets the CPU fetch switch state, button state and press flags; reading the flags clears them.

Parameters:
- SW_W, 16, number of slide-switch inputs.
- BTN_W, 4, number of push-button inputs.
- TICK_CYCLES, 2000, clk cycles between debounce samples; must be >= 2.
- CNT_W, 20, width of the tick counter; must satisfy 2^CNT_W > TICK_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- sw_raw  input  SW_W  raw switch levels, asynchronous to clk.
- btn_raw  input  BTN_W  raw button levels, active-high, asynchronous to clk.
- sw_stable  output  SW_W  debounced switch levels.
- btn_stable  output  BTN_W  debounced button levels.
- btn_press  output  BTN_W  one-cycle pulse on each debounced 0->1 button transition.
- event_pending  output  1  OR of all sticky press flags.
- rd_req  input  1  read strobe, sampled on the clk rising edge.
- rd_addr  input  2  register select.
- rd_data  output  32  registered read data, valid while rd_ack=1.
- rd_ack  output  1  high exactly one cycle after each accepted rd_req.

Behaviour:
- Reset (async, reset=1) clears everything to 0: sync flops, sample histories, tick counter, sw_stable, btn_stable, btn_press, press flags, event_pending, rd_data, rd_ack.
- Synchronizer: two flops per bit, applied to all SW_W+BTN_W inputs. The second stage is the "synced" value.
- Tick counter:
  - Counts 0..TICK_CYCLES-1 and then wraps to 0.
  - tick=1 in the cycle where the count equals TICK_CYCLES-1, so there is one tick every TICK_CYCLES cycles.
- Per-bit debounce:
  - On tick, the synced value shifts into a 3-bit history.
  - The stable output updates on the cycle after that tick, and only when all 3 history bits are equal and differ from the current stable value.
  - Any mismatch among the 3 samples holds the stable value.
  - Glitches shorter than one tick period never propagate.
  - Worst-case latency from a raw change to a stable change: 2 + 3*TICK_CYCLES + 1 cycles.
- btn_press[i]:
  - High for exactly one cycle, in the same cycle btn_stable[i] goes 0->1.
  - A 1->0 transition produces no pulse.
- Press flags (BTN_W sticky bits):
  - press_flag[i] is set by btn_press[i].
  - It is cleared by an accepted read of address 2.
  - If a set and a clear occur in the same cycle, the set wins: the flag stays 1, and the read returns the pre-clear value.
- event_pending = |press_flag, registered together with the flags.
- Read port:
  - rd_req=1 at a clk edge is accepted unconditionally; there is no busy state.
  - On the next cycle rd_ack=1 and rd_data holds the value captured at acceptance.
  - Back-to-back rd_req on consecutive cycles produces rd_ack on consecutive cycles.
  - With no request, rd_ack=0 and rd_data holds its last value.
- Address map (all values zero-extended to 32 bits):
  - addr 0: sw_stable.
  - addr 1: btn_stable.
  - addr 2: press_flag; the read clears the flags.
  - addr 3: constant 32'h0000_0000 (reserved).
- Reset asserted mid-operation: all state clears immediately. After release, debouncing restarts from stable=0 with an empty history, so a held-on input reappears after the normal latency.

Decomposition:
- Shared io package holds:
  - address constants ADDR_SW=2'd0, ADDR_BTN=2'd1, ADDR_PRESS=2'd2, ADDR_RSVD=2'd3;
  - default TICK_CYCLES.
- One natural sub-module: io_debounce_bit, a single-bit synchronizer plus 3-sample history plus stable register, with tick as an input. It is instantiated SW_W+BTN_W times via generate. The tick counter, press logic and read port stay in io_input_scan.

Test Plan (TICK_CYCLES=4 for simulation):
- Reset, then hold sw_raw=16'hA5C3 steady.
  - sw_stable must be 16'hA5C3 within 2+3*4+1=15 cycles of the first tick.
  - A read of addr 0 returns 32'h0000_A5C3 with rd_ack high for one cycle.
- Pulse btn_raw[2]=1 for 3 cycles (shorter than one tick period) → btn_stable, btn_press and event_pending stay 0.
- Hold btn_raw[1]=1 for 20 cycles, then release.
  - btn_press=4'b0010 for exactly one cycle, coinciding with btn_stable[1] rising.
  - No pulse on release.
  - event_pending=1 persists after release.
- Read addr 2 → rd_data=32'h2; the next cycle has event_pending=0; a second read of addr 2 returns 0.
- Issue rd_req on addr 2 in the same cycle as a new btn_press[0] → read returns the old flags, and flag bit 0 remains set afterward.
- Raise reset mid-debounce with sw_raw=16'hFFFF held → all outputs read 0 immediately.
  - After release, sw_stable=16'hFFFF returns after the full latency.
  - Back-to-back reads of addr 0/1/3 ack on 3 consecutive cycles with correct data.
